tcu_drl_issue_seq: RTL and testbench
====================================

Name: tcu_drl_issue_seq

Overview:
- Sequencer in front of the TCU FEDP multiply/exponent stage.
- Accepts one dot-product job: format, request id, lane valid mask and K-step count.
- Issues one datapath beat per K step, paced by operand-buffer availability and downstream accumulator credits.
- Drains outstanding beats, then pulses job completion; one job in flight at a time.

Parameters:
- K_W, 4, width of step-count field; a job has req_steps+1 steps (1..2^K_W).
- CREDITS, 4, downstream accumulator slots; the maximum number of beats outstanding.
- MASK_W, 8, lane valid-mask width (equals TCU_MAX_INPUTS).
- ID_W, 32, request id width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- req_valid, in, 1, job request.
- req_ready, out, 1, sequencer can accept a job.
- req_fmt, in, 4, format select (fmt_s encoding).
- req_id, in, ID_W, job id.
- req_mask, in, MASK_W, lane valid mask.
- req_steps, in, K_W, step count minus one.
- op_valid, in, 1, operand rows for the current step are present.
- op_ready, out, 1, operands consumed this cycle.
- dp_valid, out, 1, beat to datapath (valid_in).
- dp_fmt, out, 4, latched format.
- dp_id, out, ID_W, latched id.
- dp_mask, out, MASK_W, latched mask.
- dp_step, out, K_W, index of the current step.
- dp_first, out, 1, step index is 0.
- dp_last, out, 1, step index equals req_steps.
- cr_ret, in, 1, one accumulator credit returned.
- flush, in, 1, abort the current job.
- done_valid, out, 1, single-cycle job-complete pulse.
- done_id, out, ID_W, id of the completed job.
- done_flushed, out, 1, qualifies done_valid; the job was aborted.
- busy, out, 1, state is not IDLE.
- err_credit, out, 1, sticky credit-overflow flag.

Behaviour:
- Reset (asynchronous, any time including mid-job):
  - state=IDLE, step=0, credits=CREDITS.
  - All latched fields 0, err_credit=0.
  - Outputs: dp_valid=0, op_ready=0, done_valid=0, busy=0, req_ready=1.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid, latch fmt/id/mask/steps, set step=0, go to ISSUE next cycle.
  - The earliest beat is therefore 1 cycle after accept.
- ISSUE:
  - fire = op_valid && (credits != 0) && !flush.
  - dp_valid = op_ready = fire; fire is combinational from op_valid and registered state.
  - On fire: step++ and credits--.
  - If dp_last && fire, go to DRAIN.
  - Back-to-back beats are allowed every cycle.
  - op_valid=0 or credits=0 stalls with dp_valid=0; dp_* fields hold their values.
- DRAIN:
  - No beats are issued.
  - When credits==CREDITS, set done_valid=1 for one cycle with done_id = latched id, then go to IDLE.
  - If credits==CREDITS already on DRAIN entry, done fires in that first DRAIN cycle.
  - A one-step job with all credits free: accept at T, beat at T+1, DRAIN at T+2; done at T+2 if the credit returned at T+1, otherwise on the first cycle all credits are home.
- Credit counter:
  - Issue and cr_ret in the same cycle leave it unchanged.
  - cr_ret with credits==CREDITS and no issue: counter holds, err_credit is set sticky until reset.
- flush:
  - In ISSUE: suppresses issue that cycle and moves to DRAIN with a flushed marker.
  - The resulting done_valid pulse carries done_flushed=1.
  - Ignored in IDLE and DRAIN.
- req_ready=0 outside IDLE; req_valid there is ignored (the requester holds it).
- busy=1 in ISSUE and DRAIN.
- done_flushed=0 whenever done_valid=0.
- dp_step width is K_W; the step counter never wraps because the last step forces DRAIN. With req_steps = 2^K_W-1, dp_last asserts at step 2^K_W-1.

Test Plan:
- Basic job, credits returned immediately:
  - Stimulus: req_steps=3, op_valid=1 always, cr_ret one cycle after each beat.
  - Response: 4 beats on consecutive cycles, dp_step 0..3, dp_first on beat 0, dp_last on beat 3.
  - Response: done_valid with done_id=0x1234 and done_flushed=0 once the last credit returns.
- Credit starvation:
  - Stimulus: CREDITS=4, req_steps=7, no cr_ret until 10 cycles after accept.
  - Response: exactly 4 beats, then dp_valid=0 while credits=0.
  - Response: each subsequent cr_ret pulse enables one beat.
- Operand stall:
  - Stimulus: op_valid toggling 1,0,1,0.
  - Response: beats only when op_valid=1; op_ready==dp_valid every cycle; dp_step holds during stalls.
- Flush:
  - Stimulus: flush after beat 2 of an 8-step job.
  - Response: no further beats; done_valid with done_flushed=1 once the 2 credits return.
  - Response: req_ready=1 on the cycle after done.
- Simultaneous events and error:
  - Stimulus: issue and cr_ret in the same cycle.
  - Response: credit count unchanged.
  - Stimulus: cr_ret while idle with full credits.
  - Response: err_credit=1, stays 1 until reset.
- Reset mid-job:
  - Stimulus: assert reset asynchronously during ISSUE at step 2.
  - Response: all outputs reach their reset values immediately, credits=CREDITS.
  - Response: a new job after reset starts at dp_step=0.

Source files
------------

// File: rtl/tcu_drl_issue_seq.sv
// rtl/tcu_drl_issue_seq.sv - FEDP job issue sequencer with operand pacing and accumulator credits
module tcu_drl_issue_seq #(
    parameter int K_W     = 4,
    parameter int CREDITS = 4,
    parameter int MASK_W  = 8,
    parameter int ID_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_fmt,
    input  logic [ID_W-1:0]   req_id,
    input  logic [MASK_W-1:0] req_mask,
    input  logic [K_W-1:0]    req_steps,
    input  logic              op_valid,
    output logic              op_ready,
    output logic              dp_valid,
    output logic [3:0]        dp_fmt,
    output logic [ID_W-1:0]   dp_id,
    output logic [MASK_W-1:0] dp_mask,
    output logic [K_W-1:0]    dp_step,
    output logic              dp_first,
    output logic              dp_last,
    input  logic              cr_ret,
    input  logic              flush,
    output logic              done_valid,
    output logic [ID_W-1:0]   done_id,
    output logic              done_flushed,
    output logic              busy,
    output logic              err_credit
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_FULL = CW'(CREDITS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [K_W-1:0]      step;
    logic [K_W-1:0]      steps_q;
    logic [3:0]          fmt_q;
    logic [ID_W-1:0]     id_q;
    logic [MASK_W-1:0]   mask_q;
    logic [CW-1:0]       credits;
    logic                flushed;
    logic                fire;
    logic                cred_full;
    logic                last_step;

    assign cred_full = (credits == CRED_FULL);
    assign last_step = (step == steps_q);

    assign dp_valid     = fire;
    assign op_ready     = fire;
    assign dp_fmt       = fmt_q;
    assign dp_id        = id_q;
    assign dp_mask      = mask_q;
    assign dp_step      = step;
    assign dp_first     = (step == '0);
    assign dp_last      = last_step;
    assign done_id      = id_q;
    assign done_flushed = done_valid & flushed;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: flush wins over a pending last beat; drain waits for every credit to come home
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (flush) begin
                    state_nxt = S_DRAIN;
                end else if (fire && last_step) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: if (cred_full) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: a beat fires only in ISSUE with operands present, a free credit and no flush
    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b0;
        fire       = 1'b0;
        done_valid = 1'b0;
        case (state)
            S_IDLE:  req_ready = 1'b1;
            S_ISSUE: begin
                busy = 1'b1;
                fire = op_valid && (credits != '0) && !flush;
            end
            S_DRAIN: begin
                busy       = 1'b1;
                done_valid = cred_full;
            end
            default: ;
        endcase
    end

    // Job fields, step index, flush marker, credit counter and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fmt_q      <= '0;
            id_q       <= '0;
            mask_q     <= '0;
            steps_q    <= '0;
            step       <= '0;
            flushed    <= 1'b0;
            credits    <= CRED_FULL;
            err_credit <= 1'b0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                fmt_q   <= req_fmt;
                id_q    <= req_id;
                mask_q  <= req_mask;
                steps_q <= req_steps;
                step    <= '0;
                flushed <= 1'b0;
            end
            // The step index stays on the last step so it never wraps at 2^K_W
            if (fire && !last_step) begin
                step <= step + K_W'(1);
            end
            if (state == S_ISSUE && flush) begin
                flushed <= 1'b1;
            end
            if (fire && !cr_ret) begin
                credits <= credits - CW'(1);
            end else if (!fire && cr_ret && !cred_full) begin
                credits <= credits + CW'(1);
            end
            if (cr_ret && !fire && cred_full) begin
                err_credit <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tcu_drl_issue_seq.sv
// tb/tb_tcu_drl_issue_seq.sv - randomized and directed bench for the FEDP issue sequencer
module tb_tcu_drl_issue_seq;

    localparam int CREDITS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_fmt;
    logic [31:0] req_id;
    logic [7:0]  req_mask;
    logic [3:0]  req_steps;
    logic        op_valid;
    logic        op_ready;
    logic        dp_valid;
    logic [3:0]  dp_fmt;
    logic [31:0] dp_id;
    logic [7:0]  dp_mask;
    logic [3:0]  dp_step;
    logic        dp_first;
    logic        dp_last;
    logic        cr_ret;
    logic        flush;
    logic        done_valid;
    logic [31:0] done_id;
    logic        done_flushed;
    logic        busy;
    logic        err_credit;

    tcu_drl_issue_seq #(.K_W(4), .CREDITS(CREDITS), .MASK_W(8), .ID_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
        .req_id(req_id), .req_mask(req_mask), .req_steps(req_steps),
        .op_valid(op_valid), .op_ready(op_ready),
        .dp_valid(dp_valid), .dp_fmt(dp_fmt), .dp_id(dp_id), .dp_mask(dp_mask),
        .dp_step(dp_step), .dp_first(dp_first), .dp_last(dp_last),
        .cr_ret(cr_ret), .flush(flush),
        .done_valid(done_valid), .done_id(done_id), .done_flushed(done_flushed),
        .busy(busy), .err_credit(err_credit)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model of the job: phase 0 idle, 1 issuing, 2 draining; outstanding = beats not yet credited
    int          ph = 0;
    int          m_out = 0;
    logic [3:0]  m_step, m_steps, m_fmt;
    logic [31:0] m_id;
    logic [7:0]  m_mask;
    bit          m_fl = 0, m_err = 0;

    // Monitor bookkeeping used by directed checks
    int cyc = 0, beats = 0, first_cyc = 0, last_cyc = 0, accept_cyc = 0, done_cyc = 0;
    int done_cnt = 0;
    logic [3:0]  first_step;
    logic [31:0] last_done_id;
    bit          last_done_fl;

    // Credit responder controls
    int pending = 0;
    bit ret_en = 0, one_shot = 0, spur = 0;
    int ret_pct = 100;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model past the coming edge
    initial begin
        bit e_fire, e_done;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_dp_valid", dp_valid, 0);
                chk("rst_op_ready", op_ready, 0);
                chk("rst_done_valid", done_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_req_ready", req_ready, 1);
                chk("rst_err_credit", err_credit, 0);
                ph = 0; m_out = 0; m_fl = 0; m_err = 0;
                m_step = 0; m_steps = 0; m_fmt = 0; m_id = 0; m_mask = 0;
                beats = 0;
            end else begin
                e_fire = (ph == 1) && op_valid && (m_out < CREDITS) && !flush;
                e_done = (ph == 2) && (m_out == 0);
                chk("req_ready", req_ready, ph == 0);
                chk("busy", busy, ph != 0);
                chk("dp_valid", dp_valid, e_fire);
                chk("op_ready", op_ready, e_fire);
                chk("done_valid", done_valid, e_done);
                chk("done_flushed", done_flushed, e_done && m_fl);
                chk("err_credit", err_credit, m_err);
                if (ph == 1) begin
                    chk("dp_step", dp_step, m_step);
                    chk("dp_fmt", dp_fmt, m_fmt);
                    chk("dp_id", dp_id, m_id);
                    chk("dp_mask", dp_mask, m_mask);
                    chk("dp_first", dp_first, m_step == 0);
                    chk("dp_last", dp_last, m_step == m_steps);
                end
                if (e_done) chk("done_id", done_id, m_id);

                if (dp_valid) begin
                    beats++;
                    pending++;
                    if (beats == 1) begin
                        first_step = dp_step;
                        first_cyc = cyc;
                    end
                    last_cyc = cyc;
                end
                if (done_valid) begin
                    done_cnt++;
                    done_cyc = cyc;
                    last_done_id = done_id;
                    last_done_fl = done_flushed;
                end

                if (cr_ret && m_out == 0 && !e_fire) m_err = 1;
                if (e_fire) m_out++;
                if (cr_ret && m_out > 0) m_out--;
                case (ph)
                    0: if (req_valid) begin
                        m_fmt = req_fmt; m_id = req_id; m_mask = req_mask; m_steps = req_steps;
                        m_step = 0; m_fl = 0; ph = 1; beats = 0; accept_cyc = cyc;
                    end
                    1: if (flush) begin
                        ph = 2; m_fl = 1;
                    end else if (e_fire) begin
                        if (m_step == m_steps) ph = 2;
                        else m_step++;
                    end
                    default: if (e_done) ph = 0;
                endcase
            end
            cyc++;
        end
    end

    // Credit responder: returns one credit per cycle for beats seen, plus one-shot pulses
    initial begin
        cr_ret = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pending = 0; cr_ret = 0;
            end else if (pending > 0 && ((ret_en && $urandom_range(99) < ret_pct) || one_shot)) begin
                cr_ret = 1; pending--; one_shot = 0;
            end else if (spur) begin
                cr_ret = 1; spur = 0;
            end else begin
                cr_ret = 0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [3:0] f, input logic [31:0] id, input logic [7:0] m, input logic [3:0] s);
        int n = 0;
        req_valid = 1; req_fmt = f; req_id = id; req_mask = m; req_steps = s;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            cycle();
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 0, 1);
        cycle();
        req_valid = 0;
    endtask

    task automatic wait_done(input int max);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < max) begin
            cycle();
            n++;
        end
        chk("done_timeout", done_cnt != d0, 1);
    endtask

    initial begin
        reset = 1; req_valid = 0; req_fmt = 0; req_id = 0; req_mask = 0; req_steps = 0;
        op_valid = 0; flush = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Basic job with immediate credit return
        op_valid = 1; ret_en = 1; ret_pct = 100;
        start_job(4'h2, 32'h1234, 8'hA5, 4'd3);
        wait_done(60);
        chk("t1_beats", beats, 4);
        chk("t1_first_lat", first_cyc - accept_cyc, 1);
        chk("t1_span", last_cyc - first_cyc, 3);
        chk("t1_first_step", first_step, 0);
        chk("t1_done_lat", done_cyc - accept_cyc, 6);
        chk("t1_done_id", last_done_id, 32'h1234);
        chk("t1_done_fl", last_done_fl, 0);

        // Credit starvation, then one beat per returned credit
        ret_en = 0;
        start_job(4'h1, 32'h2222, 8'hFF, 4'd7);
        repeat (9) cycle();
        chk("t2_starved_beats", beats, 4);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            one_shot = 1;
            repeat (3) cycle();
            chk("t2_beat_per_credit", beats, 4 + i);
        end
        ret_en = 1;
        wait_done(60);
        chk("t2_done_id", last_done_id, 32'h2222);

        // Operand stall with toggling op_valid
        start_job(4'h3, 32'h3333, 8'h0F, 4'd3);
        for (int i = 0; i < 8; i++) begin
            op_valid = (i % 2 == 0);
            cycle();
        end
        op_valid = 1;
        wait_done(60);
        chk("t3_beats", beats, 4);
        chk("t3_span", last_cyc - first_cyc, 6);

        // Flush after beat 2 of an 8-step job
        ret_en = 0;
        start_job(4'h4, 32'h4444, 8'h11, 4'd7);
        cycle();
        cycle();
        flush = 1;
        cycle();
        flush = 0;
        repeat (3) cycle();
        chk("t4_beats", beats, 2);
        ret_en = 1;
        wait_done(60);
        chk("t4_done_fl", last_done_fl, 1);
        chk("t4_done_id", last_done_id, 32'h4444);
        @(negedge clk);
        chk("t4_ready_after_done", req_ready, 1);
        cycle();

        // Issue and return in the same cycle keep the pipe full
        start_job(4'h5, 32'h5555, 8'h22, 4'd7);
        wait_done(60);
        chk("t5_beats", beats, 8);
        chk("t5_span", last_cyc - first_cyc, 7);

        // Spurious return while idle sets the sticky error
        chk("t5_err_before", err_credit, 0);
        @(negedge clk);
        spur = 1;
        repeat (3) cycle();
        chk("t5_err_set", err_credit, 1);
        start_job(4'h6, 32'h5656, 8'h33, 4'd1);
        wait_done(60);
        chk("t5_err_sticky", err_credit, 1);

        // Asynchronous reset at step 2 of a job
        ret_en = 0;
        start_job(4'h7, 32'h6060, 8'h44, 4'd7);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1;
        #1;
        chk("t6_dp_valid", dp_valid, 0);
        chk("t6_op_ready", op_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_req_ready", req_ready, 1);
        chk("t6_done_valid", done_valid, 0);
        chk("t6_err", err_credit, 0);
        @(posedge clk);
        #3 reset = 0;
        cycle();
        start_job(4'h8, 32'h6666, 8'h55, 4'd5);
        repeat (6) cycle();
        chk("t6_beats_full_credits", beats, 4);
        chk("t6_first_step", first_step, 0);
        ret_en = 1;
        wait_done(60);
        chk("t6_done_id", last_done_id, 32'h6666);

        // Randomized traffic
        for (int seg = 0; seg < 6; seg++) begin
            ret_pct = $urandom_range(100, 30);
            for (int i = 0; i < 500; i++) begin
                req_valid = ($urandom_range(3) == 0);
                req_fmt = 4'($urandom);
                req_id = $urandom;
                req_mask = 8'($urandom);
                req_steps = 4'($urandom);
                op_valid = ($urandom_range(3) != 0);
                flush = ($urandom_range(40) == 0);
                #2;
                if ($urandom_range(300) == 0) spur = 1;
                @(posedge clk);
                #1;
            end
        end
        req_valid = 0; flush = 0; op_valid = 1; ret_pct = 100;
        begin
            int n = 0;
            @(negedge clk);
            while (!(req_ready && pending == 0) && n < 300) begin
                cycle();
                @(negedge clk);
                n++;
            end
            chk("quiesce_idle", req_ready, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
